// File: rtl/cpu_pkg.sv
// Shared CPU constants: program-counter width and the stack pointer-width helper.
package cpu_pkg;

    localparam int PC_WIDTH = 10;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Call-stack storage: DEPTH x WIDTH, one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the owner masks reads while the stack is empty.
module stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Return-address call stack with zero-latency top read and push/pop replace.
// Macro CALL_STACK_ERR_EN builds sticky ovf/unf flags; without it both flags read 0.
module call_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            inpush,
    output logic [WIDTH-1:0]            outpop,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        full,
    output logic                        ovf,
    output logic                        unf
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW:0]      count_q, count_d;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [PW-1:0]    top_addr;
    logic [WIDTH-1:0] rd_data;
    logic             empty_w, full_w;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == DEPTH_C);
    // Wraps to DEPTH-1 when full, which is exactly the top slot.
    assign top_addr = count_q[PW-1:0] - PW'(1);

    always_comb begin
        count_d = count_q;
        we      = 1'b0;
        waddr   = count_q[PW-1:0];
        if (push && pop) begin
            we = 1'b1;
            if (empty_w) begin
                count_d = (PW + 1)'(1);
            end else begin
                waddr = top_addr;
            end
        end else if (push) begin
            if (!full_w) begin
                we      = 1'b1;
                count_d = count_q + (PW + 1)'(1);
            end
        end else if (pop) begin
            if (!empty_w) begin
                count_d = count_q - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Reset must also cancel a write landing on the same edge.
    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we & ~reset),
        .waddr_i (waddr),
        .wdata_i (inpush),
        .raddr_i (top_addr),
        .rdata_o (rd_data)
    );

    assign outpop = empty_w ? '0 : rd_data;
    assign count  = count_q;
    assign empty  = empty_w;
    assign full   = full_w;

`ifdef CALL_STACK_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (push & ~pop & full_w);
        unf_d = unf_q | (pop & empty_w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack (WIDTH=10, DEPTH=8); flag expectations follow CALL_STACK_ERR_EN.
module tb_call_stack;

    localparam int W = 10;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         push, pop;
    logic [W-1:0] inpush;
    logic [W-1:0] outpop;
    logic [3:0]   count;
    logic         empty, full, ovf, unf;

    call_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .inpush (inpush),
        .outpop (outpop),
        .count  (count),
        .empty  (empty),
        .full   (full),
        .ovf    (ovf),
        .unf    (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cnt;
        int    top;
        bit    emp;
        bit    ful;
        bit    ov;
        bit    un;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mstack[$];
    bit           m_ovf, m_unf;
    int           n_tests = 0;
    int           n_fail  = 0;

`ifdef CALL_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_top();
        return (mstack.size() == 0) ? 0 : int'(mstack[mstack.size() - 1]);
    endfunction

    task automatic model_reset();
        mstack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_update(input logic p, input logic q, input logic [W-1:0] d);
        if (p && q) begin
            if (mstack.size() == 0) begin
                mstack.push_back(d);
                m_unf = ERR_EN;
            end else begin
                mstack[mstack.size() - 1] = d;
            end
        end else if (p) begin
            if (mstack.size() < D) mstack.push_back(d);
            else m_ovf = ERR_EN;
        end else if (q) begin
            if (mstack.size() > 0) void'(mstack.pop_back());
            else m_unf = ERR_EN;
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.cnt = mstack.size();
        e.top = model_top();
        e.emp = (mstack.size() == 0);
        e.ful = (mstack.size() == D);
        e.ov  = m_ovf;
        e.un  = m_unf;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, ".count"}, 32'(count), 32'(e.cnt));
        check_val({e.tag, ".outpop"}, 32'(outpop), 32'(e.top));
        check_val({e.tag, ".empty"}, 32'(empty), 32'(e.emp));
        check_val({e.tag, ".full"}, 32'(full), 32'(e.ful));
        check_val({e.tag, ".ovf"}, 32'(ovf), 32'(e.ov));
        check_val({e.tag, ".unf"}, 32'(unf), 32'(e.un));
    endtask

    task automatic step(input logic p, input logic q, input logic [W-1:0] d, input string tag);
        @(negedge clk);
        push   = p;
        pop    = q;
        inpush = d;
        #1;
        if (q && !p) check_val({tag, ".pre_top"}, 32'(outpop), 32'(model_top()));
        model_update(p, q, d);
        push_exp(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        inpush = '0;
        model_reset();
        #12;
        push_exp("reset");
        compare_out();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i), $sformatf("fill%0d", i));
        step(1'b1, 1'b0, 10'h3FF, "push_full");
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
        step(1'b0, 1'b1, '0, "pop_empty");
        step(1'b1, 1'b1, 10'h07F, "pp_empty");
        step(1'b0, 1'b1, '0, "pop_to0");

        step(1'b1, 1'b0, 10'h100, "b0");
        step(1'b1, 1'b0, 10'h0AA, "b1");
        step(1'b1, 1'b0, 10'h155, "b2");
        step(1'b1, 1'b1, 10'h2AA, "replace");
        step(1'b0, 1'b1, '0, "below_top");
        step(1'b1, 1'b0, 10'h201, "b3");
        step(1'b1, 1'b0, 10'h202, "b4");
        step(1'b1, 1'b0, 10'h203, "b5");

        // Asynchronous reset mid low phase, then held across an edge carrying a push.
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        push_exp("rst_async");
        compare_out();
        push   = 1'b1;
        inpush = 10'h111;
        @(posedge clk);
        #1;
        push_exp("rst_edge");
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        #1;
        push_exp("rst_release");
        compare_out();

        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(10'h040 + i), $sformatf("refill%0d", i));
        step(1'b1, 1'b1, 10'h3C3, "pp_full");
        step(1'b0, 1'b1, '0, "pp_full_pop");

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, meaning the bit width of each stored entry (matches the 10-bit PC).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; legal values are powers of two, 2 to 64.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The module SHALL have port push, input, 1 bit, a request to store inpush on top.
REQ-006 The module SHALL have port pop, input, 1 bit, a request to remove the top entry.
REQ-007 The module SHALL have port inpush, input, WIDTH bits, the data to push.
REQ-008 The module SHALL have port outpop, output, WIDTH bits, the current top entry.
REQ-009 The module SHALL have port count, output, $clog2(DEPTH)+1 bits, the number of valid entries.
REQ-010 The module SHALL have ports empty and full, outputs, 1 bit each.
REQ-011 The module SHALL have ports ovf and unf, outputs, 1 bit each, sticky overflow and underflow error flags (see Configuration).

Function
REQ-012 Push and pop SHALL be sampled at the rising edge of clk; there are no level-sensitive or combinational writes.
REQ-013 outpop SHALL be combinational from storage: mem[count-1] when count>0, and all-zeros when empty.
REQ-014 A push alone when not full SHALL write inpush to mem[count], increment count, and show it on outpop from the next cycle.
REQ-015 A pop alone when not empty SHALL decrement count; the popped value is outpop during the cycle in which pop is asserted (zero-latency read).
REQ-016 Push and pop together when not empty SHALL replace the top entry with inpush and leave count unchanged, full included, with no overflow.
REQ-017 Push and pop together when empty SHALL be treated as a push alone (count becomes 1) and SHALL set unf.
REQ-018 A push alone when full SHALL be dropped, leaving count and storage unchanged, and SHALL set ovf.
REQ-019 A pop alone when empty SHALL be ignored, leaving count at 0, and SHALL set unf.
REQ-020 empty SHALL be (count==0) and full SHALL be (count==DEPTH); both are decoded from the registered count.
REQ-021 count SHALL saturate at 0 and DEPTH and SHALL never wrap.

Reset
REQ-022 Reset assertion SHALL immediately force count=0, empty=1, full=0, outpop=0, ovf=0 and unf=0, asynchronously and without waiting for clk.
REQ-023 Storage contents SHALL NOT be reset; they are unobservable while empty.
REQ-024 Reset asserted during a push/pop cycle SHALL take priority, and that operation SHALL have no effect.

Configuration
REQ-025 With macro CALL_STACK_ERR_EN defined, ovf and unf SHALL be sticky error flags, set as above and cleared only by reset.
REQ-026 Without CALL_STACK_ERR_EN, ovf and unf SHALL be tied to 0 and no flag registers SHALL be built; drop and ignore behaviour is unchanged.

Structure
REQ-027 The shared package cpu_pkg SHALL hold the constant PC_WIDTH=10 (default for WIDTH) and the pointer-width function, ptr width = $clog2(DEPTH).
REQ-028 The storage array SHALL be one sub-module, stack_mem: DEPTH×WIDTH, one synchronous write port, one combinational read port. Pointer and flag logic SHALL stay in call_stack.

Verification (WIDTH=10, DEPTH=8, CALL_STACK_ERR_EN defined unless noted)
REQ-029 Bench SHALL cover: reset, then push 0x001..0x008 over 8 cycles -> count=8, full=1, outpop=0x008; then 8 pops -> outpop sequence 0x008..0x001, and finally empty=1, outpop=0.
REQ-030 Bench SHALL cover: while full, push 0x3FF -> count stays 8, outpop=0x008, ovf=1 and stays 1 after the following pops.
REQ-031 Bench SHALL cover: while empty, pop -> count=0, unf=1, outpop=0; with the macro undefined, the same stimulus -> unf=0.
REQ-032 Bench SHALL cover: with count=3 and top=0x155, push=pop=1 with inpush=0x2AA -> count=3, outpop=0x2AA; the entry below the top is unchanged after a following pop.
REQ-033 Bench SHALL cover: while empty, push=pop=1 with inpush=0x07F -> count=1, outpop=0x07F, unf=1.
REQ-034 Bench SHALL cover: with count=5, assert reset between clock edges -> count=0, empty=1, flags=0 before the next rising edge; a push on the reset edge is lost.
